coram_endpoint: RTL and testbench
=================================

Name: coram_endpoint

Overview:
- User-side CoRAM endpoint. Pairs one single-port-to-user synchronous memory (second port owned by the control thread / DMA) with a bidirectional word channel: an up FIFO (user -> thread) and a down FIFO (thread -> user).
- Used by compute kernels to read operand tiles, write results, and exchange control words (sizes, checksums) with the control thread.

Parameters:
- DATA_WIDTH, 32, word width of memory and channel.
- MEM_ADDR_LEN, 9, memory address width; depth 2**MEM_ADDR_LEN words.
- CH_ADDR_LEN, 4, channel FIFO address width; each FIFO holds 2**CH_ADDR_LEN words.

Ports:
- CLK  in  1  single clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- MEM_ADDR  in  MEM_ADDR_LEN  user memory address.
- MEM_D  in  DATA_WIDTH  user write data.
- MEM_WE  in  1  user write enable.
- MEM_Q  out  DATA_WIDTH  user read data.
- TM_ADDR  in  MEM_ADDR_LEN  thread-side memory address.
- TM_D  in  DATA_WIDTH  thread-side write data.
- TM_WE  in  1  thread-side write enable.
- TM_Q  out  DATA_WIDTH  thread-side read data.
- U_D  in  DATA_WIDTH  up-channel data from user.
- U_ENQ  in  1  up-channel enqueue.
- U_FULL  out  1  up-channel full.
- T_Q  out  DATA_WIDTH  up-channel data to thread.
- T_DEQ  in  1  up-channel dequeue.
- T_EMPTY  out  1  up-channel empty.
- T_D  in  DATA_WIDTH  down-channel data from thread.
- T_ENQ  in  1  down-channel enqueue.
- T_FULL  out  1  down-channel full.
- U_Q  out  DATA_WIDTH  down-channel data to user.
- U_DEQ  in  1  down-channel dequeue.
- U_EMPTY  out  1  down-channel empty.

Behaviour:
- Reset (RST=0, asynchronous):
  - Both FIFOs empty: EMPTY=1, FULL=0, pointers and counts 0.
  - T_Q, U_Q, MEM_Q, TM_Q = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all queued words.
- Memory reads: synchronous on each port. Address sampled at edge k; Q valid after edge k and held until the next edge.
- Memory writes: occur at the edge when WE=1.
- Same-port read during write: read-first; Q shows the old word.
- Cross-port access to the same address in one cycle: the reading port gets the old word.
- Both ports write the same address in one cycle: the user-port (MEM_*) write wins.
- FIFOs: each is an independent synchronous FIFO with capacity 2**CH_ADDR_LEN.
- Enqueue: accepted at the edge iff ENQ=1 and FULL=0; data captured in order. ENQ while FULL is ignored and data is lost.
- Dequeue: accepted at the edge iff DEQ=1 and EMPTY=0. The head word is registered onto Q at that edge, so it is visible from the next cycle. Q holds its value until the next accepted dequeue. DEQ while EMPTY is ignored and Q is unchanged.
- No fall-through: a word enqueued into an empty FIFO can be dequeued no earlier than the following cycle.
- Simultaneous ENQ and DEQ:
  - Each is judged on the flags current in that cycle.
  - Not empty and not full: both proceed and the count is unchanged.
  - Full: only the dequeue proceeds.
  - Empty: only the enqueue proceeds.
- FULL and EMPTY are registered, derived from the count after the edge.
  - EMPTY deasserts the cycle after the first accepted enqueue.
  - FULL asserts the cycle after the count reaches 2**CH_ADDR_LEN.
- Pointers wrap modulo 2**CH_ADDR_LEN. Count width is CH_ADDR_LEN+1.
- Required user handshake timing:
  - Cycle 0: U_DEQ=1 with U_EMPTY=0.
  - Cycle 1: U_Q holds the word.
  - The user may sample U_Q in cycle 1 or later.

Test Plan:
- Reset then idle -> T_EMPTY=U_EMPTY=1, T_FULL=U_FULL=0, T_Q=U_Q=0, MEM_Q=TM_Q=0.
- Thread writes 0..15 at TM_ADDR 0..15; user sets MEM_ADDR=5 -> MEM_Q=5 exactly one cycle later. Simultaneous write of 0xAA at address 5 on both ports -> subsequent read returns the user data.
- T_ENQ 16 words 1..16 (CH_ADDR_LEN=4) -> T_FULL=1 after the 16th; 17th word (99) dropped. 16 U_DEQ pulses yield U_Q=1..16 in order, each visible the cycle after its DEQ. U_EMPTY=1 afterwards; extra U_DEQ leaves U_Q=16.
- User enqueues checksum 0x1234 via U_ENQ -> T_EMPTY=0 next cycle; T_DEQ -> T_Q=0x1234 next cycle, T_EMPTY=1.
- FIFO holding 8 words, ENQ and DEQ asserted together for 5 cycles -> count stays 8, order preserved. On an empty FIFO, both asserted -> only enqueue takes effect and Q is unchanged.
- RST low mid-transfer with 3 queued words -> flags return to empty immediately (asynchronous), Q=0. Memory word previously written at address 5 is still readable.

Source files
------------

// File: rtl/coram_endpoint.sv
// coram_endpoint: user-side CoRAM endpoint.
//   - Dual-port synchronous memory: user port (MEM_*) and thread/DMA port (TM_*).
//     Registered read-first reads on both ports; on a same-address double write
//     the user port wins.
//   - Up channel FIFO   (U_D/U_ENQ/U_FULL -> T_Q/T_DEQ/T_EMPTY), user to thread.
//   - Down channel FIFO (T_D/T_ENQ/T_FULL -> U_Q/U_DEQ/U_EMPTY), thread to user.
//     Each FIFO registers its head word onto Q at an accepted dequeue (no
//     fall-through); FULL/EMPTY are registered from the post-edge count.
// CLK rising-edge clocked; RST asynchronous active-low. Memory is not cleared.
module coram_endpoint #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_ADDR_LEN = 9,
  parameter int unsigned CH_ADDR_LEN  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [MEM_ADDR_LEN-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]   MEM_D,
  input  logic                    MEM_WE,
  output logic [DATA_WIDTH-1:0]   MEM_Q,
  input  logic [MEM_ADDR_LEN-1:0] TM_ADDR,
  input  logic [DATA_WIDTH-1:0]   TM_D,
  input  logic                    TM_WE,
  output logic [DATA_WIDTH-1:0]   TM_Q,
  input  logic [DATA_WIDTH-1:0]   U_D,
  input  logic                    U_ENQ,
  output logic                    U_FULL,
  output logic [DATA_WIDTH-1:0]   T_Q,
  input  logic                    T_DEQ,
  output logic                    T_EMPTY,
  input  logic [DATA_WIDTH-1:0]   T_D,
  input  logic                    T_ENQ,
  output logic                    T_FULL,
  output logic [DATA_WIDTH-1:0]   U_Q,
  input  logic                    U_DEQ,
  output logic                    U_EMPTY
);

  localparam int unsigned MemDepth = 2 ** MEM_ADDR_LEN;
  localparam int unsigned ChDepth  = 2 ** CH_ADDR_LEN;
  localparam logic [CH_ADDR_LEN:0] FullCnt = {1'b1, {CH_ADDR_LEN{1'b0}}};
  localparam logic [CH_ADDR_LEN:0] ZeroCnt = '0;

  // ---------------- Memory ----------------
  logic [DATA_WIDTH-1:0] mem [MemDepth];
  logic [DATA_WIDTH-1:0] mem_q_q, mem_q_d, tm_q_q, tm_q_d;

  // Reads see the pre-edge contents, giving read-first and old-data cross-port.
  always_comb begin
    mem_q_d = mem[MEM_ADDR];
    tm_q_d  = mem[TM_ADDR];
  end

  // User write placed last so it overrides a thread write to the same address.
  always_ff @(posedge CLK) begin
    if (TM_WE)  mem[TM_ADDR]  <= TM_D;
    if (MEM_WE) mem[MEM_ADDR] <= MEM_D;
  end

  // ---------------- Up FIFO (user -> thread) ----------------
  logic [DATA_WIDTH-1:0]  up_buf [ChDepth];
  logic [CH_ADDR_LEN-1:0] up_wr_q, up_wr_d, up_rd_q, up_rd_d;
  logic [CH_ADDR_LEN:0]   up_cnt_q, up_cnt_d;
  logic                   up_full_q, up_full_d, up_empty_q, up_empty_d;
  logic [DATA_WIDTH-1:0]  up_head_q, up_head_d;
  logic                   up_enq_ok, up_deq_ok;

  always_comb begin
    up_enq_ok  = U_ENQ & ~up_full_q;
    up_deq_ok  = T_DEQ & ~up_empty_q;
    up_wr_d    = up_enq_ok ? up_wr_q + 1'b1 : up_wr_q;
    up_rd_d    = up_deq_ok ? up_rd_q + 1'b1 : up_rd_q;
    up_cnt_d   = up_cnt_q + {{CH_ADDR_LEN{1'b0}}, up_enq_ok}
                          - {{CH_ADDR_LEN{1'b0}}, up_deq_ok};
    up_full_d  = (up_cnt_d == FullCnt);
    up_empty_d = (up_cnt_d == ZeroCnt);
    up_head_d  = up_deq_ok ? up_buf[up_rd_q] : up_head_q;
  end

  always_ff @(posedge CLK) begin
    if (up_enq_ok) up_buf[up_wr_q] <= U_D;
  end

  // ---------------- Down FIFO (thread -> user) ----------------
  logic [DATA_WIDTH-1:0]  dn_buf [ChDepth];
  logic [CH_ADDR_LEN-1:0] dn_wr_q, dn_wr_d, dn_rd_q, dn_rd_d;
  logic [CH_ADDR_LEN:0]   dn_cnt_q, dn_cnt_d;
  logic                   dn_full_q, dn_full_d, dn_empty_q, dn_empty_d;
  logic [DATA_WIDTH-1:0]  dn_head_q, dn_head_d;
  logic                   dn_enq_ok, dn_deq_ok;

  always_comb begin
    dn_enq_ok  = T_ENQ & ~dn_full_q;
    dn_deq_ok  = U_DEQ & ~dn_empty_q;
    dn_wr_d    = dn_enq_ok ? dn_wr_q + 1'b1 : dn_wr_q;
    dn_rd_d    = dn_deq_ok ? dn_rd_q + 1'b1 : dn_rd_q;
    dn_cnt_d   = dn_cnt_q + {{CH_ADDR_LEN{1'b0}}, dn_enq_ok}
                          - {{CH_ADDR_LEN{1'b0}}, dn_deq_ok};
    dn_full_d  = (dn_cnt_d == FullCnt);
    dn_empty_d = (dn_cnt_d == ZeroCnt);
    dn_head_d  = dn_deq_ok ? dn_buf[dn_rd_q] : dn_head_q;
  end

  always_ff @(posedge CLK) begin
    if (dn_enq_ok) dn_buf[dn_wr_q] <= T_D;
  end

  // ---------------- Resettable state ----------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_q_q    <= '0;
      tm_q_q     <= '0;
      up_wr_q    <= '0;
      up_rd_q    <= '0;
      up_cnt_q   <= '0;
      up_full_q  <= 1'b0;
      up_empty_q <= 1'b1;
      up_head_q  <= '0;
      dn_wr_q    <= '0;
      dn_rd_q    <= '0;
      dn_cnt_q   <= '0;
      dn_full_q  <= 1'b0;
      dn_empty_q <= 1'b1;
      dn_head_q  <= '0;
    end else begin
      mem_q_q    <= mem_q_d;
      tm_q_q     <= tm_q_d;
      up_wr_q    <= up_wr_d;
      up_rd_q    <= up_rd_d;
      up_cnt_q   <= up_cnt_d;
      up_full_q  <= up_full_d;
      up_empty_q <= up_empty_d;
      up_head_q  <= up_head_d;
      dn_wr_q    <= dn_wr_d;
      dn_rd_q    <= dn_rd_d;
      dn_cnt_q   <= dn_cnt_d;
      dn_full_q  <= dn_full_d;
      dn_empty_q <= dn_empty_d;
      dn_head_q  <= dn_head_d;
    end
  end

  assign MEM_Q   = mem_q_q;
  assign TM_Q    = tm_q_q;
  assign U_FULL  = up_full_q;
  assign T_EMPTY = up_empty_q;
  assign T_Q     = up_head_q;
  assign T_FULL  = dn_full_q;
  assign U_EMPTY = dn_empty_q;
  assign U_Q     = dn_head_q;

endmodule

// File: tb/tb_coram_endpoint.sv
// Directed bench for coram_endpoint with hand-computed expectations.
module tb_coram_endpoint;

  logic        clk, rst_n;
  logic [8:0]  mem_addr, tm_addr;
  logic [31:0] mem_d, tm_d, mem_q, tm_q;
  logic        mem_we, tm_we;
  logic [31:0] u_d, t_q, t_d, u_q;
  logic        u_enq, u_full, t_deq, t_empty, t_enq, t_full, u_deq, u_empty;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  coram_endpoint #(
    .DATA_WIDTH  (32),
    .MEM_ADDR_LEN(9),
    .CH_ADDR_LEN (4)
  ) dut (
    .CLK     (clk),
    .RST     (rst_n),
    .MEM_ADDR(mem_addr),
    .MEM_D   (mem_d),
    .MEM_WE  (mem_we),
    .MEM_Q   (mem_q),
    .TM_ADDR (tm_addr),
    .TM_D    (tm_d),
    .TM_WE   (tm_we),
    .TM_Q    (tm_q),
    .U_D     (u_d),
    .U_ENQ   (u_enq),
    .U_FULL  (u_full),
    .T_Q     (t_q),
    .T_DEQ   (t_deq),
    .T_EMPTY (t_empty),
    .T_D     (t_d),
    .T_ENQ   (t_enq),
    .T_FULL  (t_full),
    .U_Q     (u_q),
    .U_DEQ   (u_deq),
    .U_EMPTY (u_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_addr = '0; tm_addr = '0; mem_d = '0; tm_d = '0; mem_we = 0; tm_we = 0;
    u_d = '0; t_d = '0; u_enq = 0; t_enq = 0; u_deq = 0; t_deq = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_t_empty", t_empty, 1);
    check_eq("rst_u_empty", u_empty, 1);
    check_eq("rst_t_full",  t_full,  0);
    check_eq("rst_u_full",  u_full,  0);
    check_eq("rst_t_q",     t_q,     0);
    check_eq("rst_u_q",     u_q,     0);

    // Thread fills words 0..15.
    tm_we = 1;
    for (int i = 0; i < 16; i++) begin
      tm_addr = 9'(i); tm_d = 32'(i);
      tick();
    end
    tm_we = 0;
    check_eq("rst_mem_q", mem_q, 0);
    mem_addr = 9'd5; tm_addr = 9'd7;
    tick();
    check_eq("mem_rd_5", mem_q, 5);
    check_eq("tm_rd_7",  tm_q,  7);
    // Read-first on the user port.
    mem_addr = 9'd6; mem_d = 32'h55; mem_we = 1;
    tick();
    mem_we = 0;
    check_eq("mem_read_first", mem_q, 6);
    tick();
    check_eq("mem_after_wr", mem_q, 32'h55);
    // Cross-port: thread writes 9 while user reads 9.
    mem_addr = 9'd9; tm_addr = 9'd9; tm_d = 32'h99; tm_we = 1;
    tick();
    tm_we = 0;
    check_eq("cross_old", mem_q, 9);
    check_eq("tm_read_first", tm_q, 9);
    tick();
    check_eq("cross_new", mem_q, 32'h99);
    // Double write: user wins.
    mem_addr = 9'd5; tm_addr = 9'd5; mem_d = 32'hAA; tm_d = 32'hBB;
    mem_we = 1; tm_we = 1;
    tick();
    mem_we = 0; tm_we = 0;
    tick();
    check_eq("dual_wr_user", mem_q, 32'hAA);
    check_eq("dual_wr_tm",   tm_q,  32'hAA);

    // Down FIFO: fill 1..16, 17th dropped.
    t_enq = 1;
    for (int i = 0; i < 16; i++) begin
      t_d = 32'(i + 1);
      tick();
      if (i == 0) check_eq("dn_empty_deassert", u_empty, 0);
      if (i == 14) check_eq("dn_not_full_15", t_full, 0);
    end
    check_eq("dn_full", t_full, 1);
    t_d = 32'd99;
    tick();
    t_enq = 0;
    check_eq("dn_full_hold", t_full, 1);
    check_eq("dn_q_before_deq", u_q, 0);
    u_deq = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq($sformatf("dn_deq_%0d", i), u_q, 32'(i + 1));
      if (i == 0) check_eq("dn_full_clear", t_full, 0);
    end
    check_eq("dn_empty_after", u_empty, 1);
    tick();
    u_deq = 0;
    check_eq("dn_deq_empty_hold", u_q, 16);
    check_eq("dn_still_empty", u_empty, 1);

    // Up FIFO checksum.
    u_d = 32'h1234; u_enq = 1;
    tick();
    u_enq = 0;
    check_eq("up_not_empty", t_empty, 0);
    t_deq = 1;
    tick();
    t_deq = 0;
    check_eq("up_q", t_q, 32'h1234);
    check_eq("up_empty", t_empty, 1);

    // Down FIFO: hold 8, then 5 cycles of simultaneous enq+deq.
    t_enq = 1;
    for (int i = 0; i < 8; i++) begin
      t_d = 32'h100 + 32'(i);
      tick();
    end
    u_deq = 1;
    for (int k = 0; k < 5; k++) begin
      t_d = 32'h200 + 32'(k);
      tick();
      check_eq($sformatf("sim_deq_%0d", k), u_q, 32'h100 + 32'(k));
    end
    t_enq = 0;
    u_deq = 0;
    check_eq("sim_not_full", t_full, 0);
    check_eq("sim_not_empty", u_empty, 0);
    u_deq = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq($sformatf("sim_drain_%0d", k), u_q,
               (k < 3) ? 32'h105 + 32'(k) : 32'h200 + 32'(k - 3));
    end
    u_deq = 0;
    check_eq("sim_drained_empty", u_empty, 1);
    // Empty FIFO with both: only the enqueue happens.
    t_d = 32'h300; t_enq = 1; u_deq = 1;
    tick();
    t_enq = 0; u_deq = 0;
    check_eq("empty_both_q", u_q, 32'h204);
    check_eq("empty_both_nonempty", u_empty, 0);
    u_deq = 1;
    tick();
    u_deq = 0;
    check_eq("empty_both_deq", u_q, 32'h300);
    check_eq("empty_both_after", u_empty, 1);

    // Async reset with 3 queued words.
    t_enq = 1;
    for (int i = 0; i < 3; i++) begin
      t_d = 32'h400 + 32'(i);
      tick();
    end
    t_enq = 0;
    mem_addr = 9'd5;
    tick();
    check_eq("pre_rst_u_empty", u_empty, 0);
    check_eq("pre_rst_mem_q", mem_q, 32'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_u_empty", u_empty, 1);
    check_eq("arst_u_q", u_q, 0);
    check_eq("arst_t_q", t_q, 0);
    check_eq("arst_mem_q", mem_q, 0);
    check_eq("arst_tm_q", tm_q, 0);
    tick();
    rst_n = 1'b1;
    u_deq = 1;
    tick();
    u_deq = 0;
    check_eq("post_rst_q", u_q, 0);
    check_eq("post_rst_empty", u_empty, 1);
    check_eq("mem_survives_rst", mem_q, 32'hAA);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
